// File: rtl/plic_pkg.sv
// Shared definitions for the platform-level interrupt controller:
// register offsets relative to the base address, bus access-size
// encodings and the source-ID width helper.
package plic_pkg;

  localparam logic [31:0] OFF_PRIO    = 32'h0000_0000;
  localparam logic [31:0] OFF_PENDING = 32'h0000_1000;
  localparam logic [31:0] OFF_ENABLE  = 32'h0000_2000;
  localparam logic [31:0] OFF_THRESH  = 32'h0020_0000;
  localparam logic [31:0] OFF_CLAIM   = 32'h0020_0004;

  typedef enum logic [1:0] {
    WLEN_BYTE  = 2'b00,
    WLEN_HALF  = 2'b01,
    WLEN_WORD  = 2'b10,
    WLEN_DWORD = 2'b11
  } wlen_e;

  // Width needed to hold IDs 0..num_src (0 means "no source").
  function automatic int id_width(input int num_src);
    return $clog2(num_src + 1);
  endfunction

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway. Tracks pending / in_flight / deferred for one
// source in level or edge mode. A claim always wins over a new request in the
// same cycle; a completion frees the gateway before new requests are looked
// at, so an edge arriving with its completion lands directly in pending.
module plic_gateway (
  input  logic clk,
  input  logic rstn,
  input  logic irq,
  input  logic mode,          // 1 = edge-triggered, 0 = level
  input  logic claim_hit,
  input  logic complete_hit,
  output logic pending
);

  logic pending_r;
  logic in_flight_r;
  logic deferred_r;
  logic irq_q_r;

  logic pending_n_s;
  logic in_flight_n_s;
  logic deferred_n_s;
  logic rise_s;

  assign rise_s  = irq & ~irq_q_r;
  assign pending = pending_r;

  // Next-state: claim/complete first, then fold in the incoming request.
  always_comb begin
    pending_n_s   = pending_r;
    in_flight_n_s = in_flight_r;
    deferred_n_s  = deferred_r;

    if (claim_hit) begin
      pending_n_s   = 1'b0;
      in_flight_n_s = 1'b1;
    end else if (complete_hit && in_flight_r) begin
      in_flight_n_s = 1'b0;
      if (deferred_r) begin
        pending_n_s  = 1'b1;
        deferred_n_s = 1'b0;
      end else begin
        pending_n_s  = pending_n_s;
      end
    end else begin
      in_flight_n_s = in_flight_n_s;
    end

    if (mode) begin
      // Only one deferred edge is kept; later edges while in flight are lost.
      if (rise_s && !in_flight_n_s) begin
        pending_n_s = 1'b1;
      end else if (rise_s) begin
        deferred_n_s = 1'b1;
      end else begin
        deferred_n_s = deferred_n_s;
      end
    end else begin
      if (irq && !in_flight_n_s) begin
        pending_n_s = 1'b1;
      end else begin
        pending_n_s = pending_n_s;
      end
    end
  end

  // Gateway state and edge-detect register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_r   <= 1'b0;
      in_flight_r <= 1'b0;
      deferred_r  <= 1'b0;
      irq_q_r     <= 1'b0;
    end else begin
      pending_r   <= pending_n_s;
      in_flight_r <= in_flight_n_s;
      deferred_r  <= deferred_n_s;
      irq_q_r     <= irq;
    end
  end

endmodule

// File: rtl/plic_multi.sv
// Platform-level interrupt controller for one hart context. Holds per-source
// priorities, an enable mask and a threshold, arbitrates the highest-priority
// eligible source (lowest ID on ties) and drives a registered machine
// external-interrupt request. Claim/complete share one bus register.
module plic_multi
  import plic_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter int          PRIO_W    = 3,
  parameter logic [31:0] EDGE_MASK = 32'h0000_0000,
  parameter int          XLEN      = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0C00_0000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [31:0]        data_addr,
  input  logic               wen,
  input  logic               ren,
  input  logic [XLEN-1:0]    wdata,
  input  logic [1:0]         wlen,
  output logic [XLEN-1:0]    rdata,
  input  logic [NUM_SRC-1:0] irq,
  input  logic               hold_mem,
  output logic               external_interrupt
);

  localparam int ID_W = id_width(NUM_SRC);

  logic [31:0]        offset_s;
  logic               wr_word_s;
  logic               claim_sel_s;
  logic               claim_rd_s;
  logic               complete_s;
  logic [ID_W-1:0]    complete_id_s;

  logic [PRIO_W-1:0]  prio_r [NUM_SRC];
  logic [NUM_SRC-1:0] enable_r;
  logic [PRIO_W-1:0]  thresh_r;
  logic               ext_r;

  logic [NUM_SRC-1:0] pending_s;
  logic [ID_W-1:0]    best_id_s;
  logic [PRIO_W-1:0]  best_prio_s;
  logic [PRIO_W-1:0]  prio_rd_s;
  logic [XLEN-1:0]    rdata_s;

  assign offset_s      = data_addr - BASE_ADDR;
  assign wr_word_s     = wen && (wlen == WLEN_WORD);
  assign claim_sel_s   = (offset_s == OFF_CLAIM);
  // A simultaneous write takes the bus; the read then has no claim effect.
  assign claim_rd_s    = ren && !wen && claim_sel_s;
  assign complete_s    = wr_word_s && claim_sel_s &&
                         (wdata >= XLEN'(1)) && (wdata <= XLEN'(NUM_SRC));
  assign complete_id_s = wdata[ID_W-1:0];

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_gw
      plic_gateway u_gw (
        .clk          (clk),
        .rstn         (rstn),
        .irq          (irq[g]),
        .mode         (EDGE_MASK[g]),
        .claim_hit    (claim_rd_s && (best_id_s == ID_W'(g + 1))),
        .complete_hit (complete_s && (complete_id_s == ID_W'(g + 1))),
        .pending      (pending_s[g])
      );
    end
  endgenerate

  // Priority registers for sources 1..NUM_SRC (source 0 has none).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wr_word_s && (offset_s == OFF_PRIO + 32'(4 * (i + 1)))) begin
          prio_r[i] <= wdata[PRIO_W-1:0];
        end else begin
          prio_r[i] <= prio_r[i];
        end
      end
    end
  end

  // Enable mask and threshold registers; bit 0 of the enable vector is not stored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      enable_r <= '0;
      thresh_r <= '0;
    end else begin
      if (wr_word_s && (offset_s == OFF_ENABLE)) begin
        enable_r <= wdata[NUM_SRC:1];
      end else begin
        enable_r <= enable_r;
      end
      if (wr_word_s && (offset_s == OFF_THRESH)) begin
        thresh_r <= wdata[PRIO_W-1:0];
      end else begin
        thresh_r <= thresh_r;
      end
    end
  end

  // Arbiter: strict '>' while scanning upward keeps the lowest ID on ties;
  // a zero priority can never beat the initial zero, so it is never eligible.
  always_comb begin
    best_id_s   = '0;
    best_prio_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_s[i] && enable_r[i] && (prio_r[i] > best_prio_s)) begin
        best_id_s   = ID_W'(i + 1);
        best_prio_s = prio_r[i];
      end else begin
        best_id_s   = best_id_s;
        best_prio_s = best_prio_s;
      end
    end
  end

  // Priority read mux; yields 0 for any address outside the priority block.
  always_comb begin
    prio_rd_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      prio_rd_s = prio_rd_s |
                  ((offset_s == OFF_PRIO + 32'(4 * (i + 1))) ? prio_r[i] : '0);
    end
  end

  // Combinational read data, zero when not reading.
  always_comb begin
    rdata_s = '0;
    if (ren) begin
      case (offset_s)
        OFF_PENDING: rdata_s = XLEN'({pending_s, 1'b0});
        OFF_ENABLE:  rdata_s = XLEN'({enable_r, 1'b0});
        OFF_THRESH:  rdata_s = XLEN'(thresh_r);
        OFF_CLAIM:   rdata_s = XLEN'(best_id_s);
        default:     rdata_s = XLEN'(prio_rd_s);
      endcase
    end else begin
      rdata_s = '0;
    end
  end

  assign rdata = rdata_s;

  // Registered interrupt request, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ext_r <= 1'b0;
    end else if (hold_mem) begin
      ext_r <= ext_r;
    end else begin
      ext_r <= (best_id_s != '0) && (best_prio_s > thresh_r);
    end
  end

  assign external_interrupt = ext_r;

endmodule

// File: tb/tb_plic_multi.sv
// Directed bench for plic_multi: a vector table for register access and
// claim arbitration, then hand-written multi-cycle sequences for latency,
// threshold, stall hold, edge deferral and reset.
module tb_plic_multi;

  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'h0C00_0000;
  localparam logic [31:0] PEND = 32'h0000_1000;
  localparam logic [31:0] EN   = 32'h0000_2000;
  localparam logic [31:0] TH   = 32'h0020_0000;
  localparam logic [31:0] CL   = 32'h0020_0004;
  localparam logic [1:0]  W    = 2'b10;
  localparam logic [1:0]  DW   = 2'b11;
  localparam logic [1:0]  BY   = 2'b00;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] data_addr;
  logic        wen;
  logic        ren;
  logic [63:0] wdata;
  logic [1:0]  wlen;
  logic [63:0] rdata;
  logic [7:0]  irq;
  logic        hold_mem;
  logic        external_interrupt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  plic_multi #(
    .NUM_SRC   (NSRC),
    .PRIO_W    (3),
    .EDGE_MASK (32'h0000_0001),
    .XLEN      (64),
    .BASE_ADDR (BASE)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .data_addr          (data_addr),
    .wen                (wen),
    .ren                (ren),
    .wdata              (wdata),
    .wlen               (wlen),
    .rdata              (rdata),
    .irq                (irq),
    .hold_mem           (hold_mem),
    .external_interrupt (external_interrupt)
  );

  typedef struct {
    logic [7:0]  irq;
    logic        w;
    logic        r;
    logic [31:0] off;
    logic [1:0]  len;
    logic [63:0] d;
    logic        chk_rd;
    logic [63:0] exp_rd;
    logic        chk_ext;
    logic        exp_ext;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic [7:0] i, input logic w, input logic r,
                               input logic [31:0] off, input logic [1:0] len,
                               input logic [63:0] d, input logic cr,
                               input logic [63:0] er, input logic ce, input logic ee);
    vec_t v;
    v.irq = i; v.w = w; v.r = r; v.off = off; v.len = len; v.d = d;
    v.chk_rd = cr; v.exp_rd = er; v.chk_ext = ce; v.exp_ext = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_idle;
    wen = 1'b0; ren = 1'b0; wdata = 64'h0; wlen = W; data_addr = BASE;
  endtask

  task automatic wr(input logic [31:0] off, input logic [63:0] d);
    data_addr = BASE + off; wen = 1'b1; wlen = W; wdata = d;
    tick;
    bus_idle;
  endtask

  task automatic rd(input string name, input logic [31:0] off, input logic [63:0] exp);
    data_addr = BASE + off; ren = 1'b1;
    #1 check(name, rdata, exp);
    tick;
    bus_idle;
  endtask

  task automatic ext_is(input string name, input logic exp);
    check(name, {63'h0, external_interrupt}, {63'h0, exp});
  endtask

  initial begin
    rstn = 1'b0; irq = 8'h00; hold_mem = 1'b0;
    bus_idle;

    //            irq    w     r     off          len d          crd  exp      cext eext
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, PEND,       W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, EN,         W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, TH,         W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 32'hC,      W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, EN,         W,  64'h1FE,   1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, EN,         W,  64'h0,     1'b1, 64'h1FE, 1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, EN,         DW, 64'h0,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, EN,         W,  64'h0,     1'b1, 64'h1FE, 1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, EN,         W,  64'h1FF,   1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, EN,         W,  64'h0,     1'b1, 64'h1FE, 1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, 32'h8,      W,  64'h4,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, 32'h14,     W,  64'h4,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, 32'hC,      W,  64'hFA,    1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 32'hC,      W,  64'h0,     1'b1, 64'h2,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 32'h8,      W,  64'h0,     1'b1, 64'h4,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 32'h0,      W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 32'h24,     W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, TH,         W,  64'h1,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, TH,         W,  64'h0,     1'b1, 64'h1,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b0, TH,         W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, TH,         BY, 64'h7,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, TH,         W,  64'h0,     1'b1, 64'h1,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, 32'h1004,   W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b1, TH,         W,  64'h1,     1'b1, 64'h1,   1'b1, 1'b0));
    // sources 2 and 5 at equal priority 4, level requests
    tbl.push_back(mkv(8'h12, 1'b0, 1'b0, PEND,       W,  64'h0,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, PEND,       W,  64'h0,     1'b1, 64'h24,  1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b1, 1'b1, CL,         W,  64'h0,     1'b1, 64'h2,   1'b1, 1'b1));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, CL,         W,  64'h0,     1'b1, 64'h2,   1'b1, 1'b1));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, CL,         W,  64'h0,     1'b1, 64'h5,   1'b1, 1'b1));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, CL,         W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b1));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, PEND,       W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b1, 1'b0, CL,         W,  64'h9,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b1, 1'b0, CL,         W,  64'h3,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b1, 1'b0, CL,         W,  64'h1_0000_0002, 1'b0, 64'h0, 1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b1, 1'b0, CL,         DW, 64'h2,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, PEND,       W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b1, 1'b0, CL,         W,  64'h2,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, PEND,       W,  64'h0,     1'b1, 64'h4,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h12, 1'b0, 1'b1, CL,         W,  64'h0,     1'b1, 64'h2,   1'b1, 1'b1));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, CL,         W,  64'h2,     1'b0, 64'h0,   1'b1, 1'b1));
    tbl.push_back(mkv(8'h00, 1'b1, 1'b0, CL,         W,  64'h5,     1'b0, 64'h0,   1'b1, 1'b0));
    tbl.push_back(mkv(8'h00, 1'b0, 1'b1, PEND,       W,  64'h0,     1'b1, 64'h0,   1'b1, 1'b0));

    @(negedge clk);
    tick;
    rstn = 1'b1;

    foreach (tbl[i]) begin
      irq = tbl[i].irq; wen = tbl[i].w; ren = tbl[i].r;
      data_addr = BASE + tbl[i].off; wlen = tbl[i].len; wdata = tbl[i].d;
      #1;
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
      if (tbl[i].chk_ext) check($sformatf("vec%0d_ext", i), {63'h0, external_interrupt},
                                {63'h0, tbl[i].exp_ext});
      tick;
    end
    bus_idle;
    irq = 8'h00;

    // level source 3 (priority 2 > threshold 1): latency and claim drop
    irq = 8'h04;
    tick;            ext_is("lvl_pend_edge", 1'b0);
    tick;            ext_is("lvl_irq_edge", 1'b1);
    rd("lvl_claim", CL, 64'h3);
    ext_is("lvl_claim_edge", 1'b1);
    tick;            ext_is("lvl_claim_drop", 1'b0);
    irq = 8'h00;
    wr(CL, 64'h3);
    rd("lvl_pend_clear", PEND, 64'h0);

    // threshold equal to priority blocks, lowering it releases
    wr(TH, 64'h4);
    irq = 8'h02;
    tick; tick;      ext_is("th_equal_a", 1'b0);
    tick;            ext_is("th_equal_b", 1'b0);
    rd("th_pending", PEND, 64'h4);
    wr(TH, 64'h3);   ext_is("th_write_edge", 1'b0);
    tick;            ext_is("th_fire", 1'b1);
    rd("th_claim", CL, 64'h2);
    irq = 8'h00;
    wr(CL, 64'h2);
    wr(TH, 64'h1);
    tick;            ext_is("th_idle", 1'b0);

    // stall freezes the output in both directions
    hold_mem = 1'b1; irq = 8'h02;
    tick;            ext_is("hold_rise_a", 1'b0);
    tick;            ext_is("hold_rise_b", 1'b0);
    tick;            ext_is("hold_rise_c", 1'b0);
    hold_mem = 1'b0;
    tick;            ext_is("hold_release_rise", 1'b1);
    hold_mem = 1'b1;
    rd("hold_claim", CL, 64'h2);
    ext_is("hold_fall_a", 1'b1);
    tick;            ext_is("hold_fall_b", 1'b1);
    tick;            ext_is("hold_fall_c", 1'b1);
    hold_mem = 1'b0;
    tick;            ext_is("hold_release_fall", 1'b0);
    irq = 8'h00;
    wr(CL, 64'h2);

    // edge source 1: deferral of a second edge while in flight
    wr(32'h4, 64'h3);
    irq = 8'h01; tick; irq = 8'h00;
    ext_is("edge_pend_edge", 1'b0);
    tick;            ext_is("edge_fire", 1'b1);
    rd("edge_claim", CL, 64'h1);
    irq = 8'h01; tick; irq = 8'h00;
    ext_is("defer_no_irq", 1'b0);
    rd("defer_not_pending", PEND, 64'h0);
    ext_is("defer_no_irq_b", 1'b0);
    wr(CL, 64'h1);   ext_is("defer_complete_edge", 1'b0);
    tick;            ext_is("defer_fire", 1'b1);
    rd("defer_pending", PEND, 64'h2);
    wr(32'h4, 64'h0); ext_is("prio0_write_edge", 1'b1);
    tick;            ext_is("prio0_drop", 1'b0);
    rd("prio0_keeps_pending", PEND, 64'h2);
    wr(32'h4, 64'h3);
    tick;            ext_is("prio_restore", 1'b1);
    rd("edge_claim2", CL, 64'h1);
    wr(CL, 64'h1);

    // reset while a source is in flight
    irq = 8'h02;
    tick; tick;
    rd("rst_claim", CL, 64'h2);
    rstn = 1'b0;
    tick;
    rstn = 1'b1; irq = 8'h00;
    ext_is("rst_ext", 1'b0);
    rd("rst_enable", EN, 64'h0);
    rd("rst_pending", PEND, 64'h0);
    rd("rst_thresh", TH, 64'h0);
    rd("rst_prio2", 32'h8, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
